// File: rtl/spi_feeder_pkg.sv
// Shared constants for the SPI byte feeder: FIFO geometry, CS guard gap,
// D/C tag values and the sequencer state encoding.
package spi_feeder_pkg;

    localparam int DEPTH         = 16;
    localparam int ADDR_W        = 4;
    localparam int CS_GAP_CYCLES = 4;
    localparam int ENTRY_W       = 9;
    localparam int DC_BIT        = 8;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_RUN  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_byte_feeder_if.sv
// Bus bundle between the CPU write side, the feeder and the SPI core.
// Handshakes: a push happens on a clock edge where wr_en=1 and fifo_full=0 (otherwise
// it is dropped); spiStart is held high until spiBusy=1 is sampled, and the byte is
// done when spiBusy returns to 0.
interface spi_byte_feeder_if #(parameter int ADDR_W = 4);

    logic              wr_en;
    logic [8:0]        wr_data;
    logic              flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_level;
    logic [7:0]        spiData;
    logic              spiDC;
    logic              spiCS;
    logic              spiStart;
    logic              spiBusy;

    modport slave (
        input  wr_en, wr_data, flush, spiBusy,
        output fifo_full, fifo_empty, fifo_level, spiData, spiDC, spiCS, spiStart
    );

    modport master (
        output wr_en, wr_data, flush, spiBusy,
        input  fifo_full, fifo_empty, fifo_level, spiData, spiDC, spiCS, spiStart
    );

endinterface

// File: rtl/spi_feeder_fifo.sv
// DEPTH x WIDTH synchronous FIFO with full/empty/level and a synchronous flush
// that wins over push and pop. Head entry is visible on rd_data without a pop.
module spi_feeder_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    input  logic              flush,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count carries the extra bit for full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/spi_byte_feeder.sv
// Feeds D/C-tagged bytes from a FIFO into the SPI core, keeping CS asserted across
// back-to-back bytes. Optional burst-complete pulse on irq when SPI_FEEDER_IRQ_EN is defined.
module spi_byte_feeder
    import spi_feeder_pkg::*;
#(
    parameter int P_DEPTH         = DEPTH,
    parameter int P_ADDR_W        = ADDR_W,
    parameter int P_CS_GAP_CYCLES = CS_GAP_CYCLES
) (
    input  logic                masterClk,
    input  logic                rst,
    spi_byte_feeder_if.slave    bus,
    output logic                seq_busy,
    output logic                irq,
    output state_t              dbg_state
);

    localparam int GAP_W = $clog2(P_CS_GAP_CYCLES) + 1;

    state_t               state;
    logic [GAP_W-1:0]     gap_cnt;
    logic [7:0]           spi_data;
    logic                 spi_dc;
    logic                 spi_cs;
    logic                 spi_start;
    logic [ENTRY_W-1:0]   head;
    logic                 head_avail;
    logic                 fifo_pop;
    logic                 burst_done;

    spi_feeder_fifo #(
        .DEPTH  (P_DEPTH),
        .ADDR_W (P_ADDR_W),
        .WIDTH  (ENTRY_W)
    ) u_fifo (
        .clk     (masterClk),
        .rst     (rst),
        .push    (bus.wr_en),
        .wr_data (bus.wr_data),
        .pop     (fifo_pop),
        .flush   (bus.flush),
        .rd_data (head),
        .full    (bus.fifo_full),
        .empty   (bus.fifo_empty),
        .level   (bus.fifo_level)
    );

    // A flush in the same cycle hides the head so the FSM never latches a dropped entry.
    assign head_avail = !bus.fifo_empty && !bus.flush;
    assign fifo_pop   = head_avail &&
                        ((state == ST_IDLE) || (state == ST_RUN && !bus.spiBusy));
    assign burst_done = (state == ST_RUN) && !bus.spiBusy && !head_avail;

    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            spi_data  <= 8'h00;
            spi_dc    <= DC_CMD;
            spi_cs    <= 1'b0;
            spi_start <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (head_avail) begin
                        spi_data <= head[7:0];
                        spi_dc   <= head[DC_BIT];
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    spi_cs <= 1'b1;
                    state  <= ST_REQ;
                end
                ST_REQ: begin
                    if (bus.spiBusy) begin
                        spi_start <= 1'b0;
                        state     <= ST_RUN;
                    end else begin
                        spi_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus.spiBusy) begin
                        if (head_avail) begin
                            spi_data <= head[7:0];
                            spi_dc   <= head[DC_BIT];
                            state    <= ST_REQ;
                        end else begin
                            spi_cs  <= 1'b0;
                            gap_cnt <= GAP_W'(P_CS_GAP_CYCLES - 1);
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_FEEDER_IRQ_EN
    logic irq_q;

    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= burst_done;
        end
    end

    assign irq = irq_q;
`else
    logic unused_burst_done;
    assign unused_burst_done = burst_done;
    assign irq = 1'b0;
`endif

    assign bus.spiData  = spi_data;
    assign bus.spiDC    = spi_dc;
    assign bus.spiCS    = spi_cs;
    assign bus.spiStart = spi_start;
    assign seq_busy     = (state != ST_IDLE);
    assign dbg_state    = state;

endmodule
